// File: rtl/msg_uart_tx.sv
// msg_uart_tx: writable message buffer serialised over an integrated 8N1-style UART transmitter.
// Define MSGTX_PARITY_EN to append an even-parity bit after the data bits of every character.
module msg_uart_tx #(
    parameter int CLOCKS_PER_BAUD = 1250,
    parameter int MSG_DEPTH       = 32,
    parameter int AW              = $clog2(MSG_DEPTH),
    parameter int DATA_BITS       = 8,
    parameter int STOP_BITS       = 1,
    parameter int REPEAT_CLOCKS   = 12_000_000
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW:0]   i_len,
    input  logic          i_start,
    input  logic          i_abort,
    output logic          o_uart_tx,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW-1:0] o_index
);

    localparam int BW = $clog2(CLOCKS_PER_BAUD);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLOCKS_PER_BAUD - 1);

    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic [AW:0]   len_q;
    logic          abort_q;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    mem [MSG_DEPTH];
    logic          rep_tick;
    logic          trigger;
    logic          baud_end;
    logic          last_char;
    logic          line_nxt;

    generate
        if (REPEAT_CLOCKS > 0) begin : g_rep
            localparam int RW = (REPEAT_CLOCKS > 1) ? $clog2(REPEAT_CLOCKS) : 1;
            localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_CLOCKS - 1);
            logic [RW-1:0] rep_cnt;

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset)
                    rep_cnt <= REP_RELOAD;
                else if (rep_cnt == '0)
                    rep_cnt <= REP_RELOAD;
                else
                    rep_cnt <= rep_cnt - RW'(1);
            end
            assign rep_tick = (rep_cnt == '0);
        end else begin : g_norep
            assign rep_tick = 1'b0;
        end
    endgenerate

    assign trigger   = (i_start || rep_tick) && (i_len != '0);
    assign baud_end  = (baud_cnt == '0);
    assign last_char = (({1'b0, o_index} + (AW+1)'(1)) == len_q);

    always_ff @(posedge i_clk) begin
        if (i_wr)
            mem[i_waddr] <= i_wdata;
    end

`ifdef MSGTX_PARITY_EN
    localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
    logic par_q;
`endif

    // Character datapath: synchronous buffer read during FETCH, LSB-first shift during DATA
    always_ff @(posedge i_clk) begin
        if (state == FETCH) begin
            shreg <= mem[o_index];
`ifdef MSGTX_PARITY_EN
            par_q <= ^(mem[o_index] & DATA_MASK);
`endif
        end else if (state == DATA && baud_end) begin
            shreg <= {1'b0, shreg[7:1]};
        end
    end

    always_comb begin
        line_nxt = 1'b1;
        case (state)
            START:   line_nxt = 1'b0;
            DATA:    line_nxt = shreg[0];
`ifdef MSGTX_PARITY_EN
            PARITY:  line_nxt = par_q;
`endif
            default: line_nxt = 1'b1;
        endcase
    end

    // The line register follows the state one clock later, so every bit keeps its full width
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_index   <= '0;
            o_uart_tx <= 1'b1;
            abort_q   <= 1'b0;
            len_q     <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
        end else begin
            o_done    <= 1'b0;
            o_uart_tx <= line_nxt;
            if (state != IDLE && i_abort)
                abort_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state   <= FETCH;
                        o_busy  <= 1'b1;
                        o_index <= '0;
                        len_q   <= i_len;
                    end
                end
                FETCH: begin
                    state    <= START;
                    baud_cnt <= BAUD_RELOAD;
                end
                START: begin
                    if (baud_end) begin
                        state    <= DATA;
                        baud_cnt <= BAUD_RELOAD;
                        bit_cnt  <= 3'(DATA_BITS - 1);
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_cnt == '0) begin
`ifdef MSGTX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
                            bit_cnt <= 3'(STOP_BITS - 1);
`endif
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                PARITY: begin
                    if (baud_end) begin
                        state    <= STOP;
                        baud_cnt <= BAUD_RELOAD;
                        bit_cnt  <= 3'(STOP_BITS - 1);
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        if (bit_cnt == '0) begin
                            if (abort_q || last_char) begin
                                state   <= IDLE;
                                o_busy  <= 1'b0;
                                o_index <= '0;
                                o_done  <= !abort_q;
                                abort_q <= 1'b0;
                            end else begin
                                state   <= FETCH;
                                o_index <= o_index + AW'(1);
                            end
                        end else begin
                            bit_cnt  <= bit_cnt - 3'd1;
                            baud_cnt <= BAUD_RELOAD;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_uart_tx.sv
// Bench for msg_uart_tx: table of transactions with random message bytes, checked clock by clock
// against a frame-arithmetic model, plus reset, empty-message and auto-repeat sequences.
module tb_msg_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int DB    = 8;
    localparam int SB    = 1;
    localparam int REP_B = 200;
`ifdef MSGTX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int PER = 1 + (1 + DB + PB + SB) * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       wr, start, abort, tx, busy, done;
    logic [1:0] waddr, idx;
    logic [7:0] wdata;
    logic [2:0] len;
    logic       wr_b, start_b, abort_b, tx_b, busy_b, done_b;
    logic [1:0] waddr_b, idx_b;
    logic [7:0] wdata_b;
    logic [2:0] len_b;

    msg_uart_tx #(.CLOCKS_PER_BAUD(CPB), .MSG_DEPTH(DEPTH), .DATA_BITS(DB), .STOP_BITS(SB),
                  .REPEAT_CLOCKS(0)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_waddr(waddr), .i_wdata(wdata), .i_len(len),
        .i_start(start), .i_abort(abort), .o_uart_tx(tx), .o_busy(busy), .o_done(done),
        .o_index(idx));

    msg_uart_tx #(.CLOCKS_PER_BAUD(CPB), .MSG_DEPTH(DEPTH), .DATA_BITS(DB), .STOP_BITS(SB),
                  .REPEAT_CLOCKS(REP_B)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_wr(wr_b), .i_waddr(waddr_b), .i_wdata(wdata_b),
        .i_len(len_b), .i_start(start_b), .i_abort(abort_b), .o_uart_tx(tx_b),
        .o_busy(busy_b), .o_done(done_b), .o_index(idx_b));

    typedef struct {
        logic [3:0][7:0] msg;
        bit              rnd;
        int              len;
        int              abort_at;
        int              wr_at;
        int              wr_addr;
        logic [7:0]      wr_data;
        int              st_at;
        int              chars;
        bit              done;
    } vec_t;

    vec_t tbl [9];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic [31:0] m, bit r, int l, int ab, int wa, int wad,
                                logic [7:0] wd, int st, int ch, bit dn);
        vec_t v;
        v.msg = m; v.rnd = r; v.len = l; v.abort_at = ab; v.wr_at = wa; v.wr_addr = wad;
        v.wr_data = wd; v.st_at = st; v.chars = ch; v.done = dn;
        return v;
    endfunction

    // Line level after edge k of a transaction triggered at edge 0, from the frame layout
    function automatic logic exp_line(int k, logic [3:0][7:0] m, int chars);
        int j, c, o, s;
        if (k <= 0) return 1'b1;
        j = k - 1;
        if (j >= chars * PER) return 1'b1;
        c = j / PER;
        o = j % PER;
        if (o == 0) return 1'b1;
        s = (o - 1) / CPB;
        if (s == 0) return 1'b0;
        if (s <= DB) return m[c][s-1];
        if (PB == 1 && s == DB + 1) return ^m[c][DB-1:0];
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, a, e);
        end
    endtask

    task automatic note(inout int bk, inout logic [7:0] ba, inout logic [7:0] be,
                        input int k, input logic [7:0] a, input logic [7:0] e);
        if (a !== e && bk < 0) begin
            bk = k; ba = a; be = e;
        end
    endtask

    task automatic report(input string nm, input int bk, input logic [7:0] ba, input logic [7:0] be);
        total++;
        if (bk >= 0) begin
            bad++;
            $display("FAIL %s at clock %0d: got %0h, want %0h", nm, bk, ba, be);
        end
    endtask

    task automatic run_entry(input vec_t v, input int id);
        logic [3:0][7:0] m, me;
        int         bk_l = -1, bk_b = -1, bk_d = -1, bk_i = -1;
        logic [7:0] a_l = 0, e_l = 0, a_b = 0, e_b = 0, a_d = 0, e_d = 0, a_i = 0, e_i = 0;
        int         nclk;
        for (int i = 0; i < DEPTH; i++)
            m[i] = v.rnd ? 8'($urandom) : v.msg[i];
        for (int i = 0; i < DEPTH; i++) begin
            wr = 1'b1; waddr = 2'(i); wdata = m[i];
            step();
        end
        wr = 1'b0;
        me = m;
        if (v.wr_at > 0 && v.wr_at <= v.wr_addr * PER)
            me[v.wr_addr] = v.wr_data;
        nclk = v.chars * PER;
        len = 3'(v.len); start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k <= nclk + 4; k++) begin
            note(bk_l, a_l, e_l, k, {7'd0, tx}, {7'd0, exp_line(k, me, v.chars)});
            note(bk_b, a_b, e_b, k, {7'd0, busy}, {7'd0, (k < nclk)});
            note(bk_d, a_d, e_d, k, {7'd0, done}, {7'd0, (k == nclk) && v.done});
            note(bk_i, a_i, e_i, k, {6'd0, idx}, (k < nclk) ? 8'(k / PER) : 8'd0);
            abort = (k + 1 == v.abort_at);
            start = (k + 1 == v.st_at);
            wr    = (k + 1 == v.wr_at);
            if (wr) begin
                waddr = 2'(v.wr_addr); wdata = v.wr_data;
            end
            step();
        end
        abort = 1'b0; start = 1'b0; wr = 1'b0;
        report($sformatf("e%0d line", id), bk_l, a_l, e_l);
        report($sformatf("e%0d busy", id), bk_b, a_b, e_b);
        report($sformatf("e%0d done", id), bk_d, a_d, e_d);
        report($sformatf("e%0d index", id), bk_i, a_i, e_i);
    endtask

    initial begin
        int         bk;
        logic [7:0] ba, be;
        int         rises[$];
        int         durs[$];
        int         dcount, hi;
        logic       prev;

        wr = 0; waddr = 0; wdata = 0; len = 0; start = 0; abort = 0;
        wr_b = 0; waddr_b = 0; wdata_b = 0; len_b = 3'd1; start_b = 0; abort_b = 0;

        tbl[0] = mk(32'h0000_6948, 1'b0, 2, 0,       0,  0, 8'h00, 0,  2, 1'b1);
        tbl[1] = mk(32'h0,         1'b1, 3, 15,      0,  0, 8'h00, 0,  1, 1'b0);
        tbl[2] = mk(32'h0,         1'b1, 4, 0,       0,  0, 8'h00, 0,  4, 1'b1);
        tbl[3] = mk(32'h0,         1'b1, 2, 0,       10, 1, 8'h5A, 0,  2, 1'b1);
        tbl[4] = mk(32'h0,         1'b1, 1, 0,       0,  0, 8'h00, 20, 1, 1'b1);
        tbl[5] = mk(32'h0,         1'b1, 3, PER + 5, 0,  0, 8'h00, 0,  2, 1'b0);
        tbl[6] = mk(32'h0,         1'b1, 2, PER + 30,0,  0, 8'h00, 0,  2, 1'b0);
        tbl[7] = mk(32'h0000_0007, 1'b0, 1, 0,       0,  0, 8'h00, 0,  1, 1'b1);
        tbl[8] = mk(32'h0,         1'b1, 3, PER - 1, 0,  0, 8'h00, 0,  1, 1'b0);

        step();
        step();
        check("reset tx", {31'd0, tx}, 1);
        check("reset busy", {31'd0, busy}, 0);
        check("reset done", {31'd0, done}, 0);
        check("reset index", {30'd0, idx}, 0);
        check("reset tx_b", {31'd0, tx_b}, 1);
        check("reset busy_b", {31'd0, busy_b}, 0);
        wr_b = 1'b1; waddr_b = 2'd0; wdata_b = 8'h55;
        step();
        wr_b = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run_entry(tbl[i], i);

        // Empty message: start must be ignored
        len = 3'd0; start = 1'b1;
        step();
        start = 1'b0;
        bk = -1; ba = 0; be = 0;
        for (int k = 0; k < 12; k++) begin
            note(bk, ba, be, k, {6'd0, busy, tx}, 8'h01);
            step();
        end
        report("len0 idle", bk, ba, be);

        // Reset in the middle of character 1's start bit
        for (int i = 0; i < 2; i++) begin
            wr = 1'b1; waddr = 2'(i); wdata = 8'hC3;
            step();
        end
        wr = 1'b0;
        len = 3'd2; start = 1'b1;
        step();
        start = 1'b0;
        repeat (PER + 3) step();
        check("midframe line", {31'd0, tx}, 0);
        check("midframe index", {30'd0, idx}, 1);
        rst = 1'b1;
        #1;
        check("async rst tx", {31'd0, tx}, 1);
        check("async rst busy", {31'd0, busy}, 0);
        check("async rst index", {30'd0, idx}, 0);
        step();
        rst = 1'b0;

        // Auto-repeat on the second instance, with starts while busy and coincident with a tick
        dcount = 0; hi = 0; prev = 1'b0;
        for (int k = 1; k <= 720; k++) begin
            start_b = (k == 220 || k == 400);
            step();
            if (busy_b && !prev) rises.push_back(k);
            if (busy_b) hi++;
            else if (prev) begin
                durs.push_back(hi);
                hi = 0;
            end
            if (done_b) dcount++;
            prev = busy_b;
        end
        start_b = 1'b0;
        check("repeat frames", rises.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("repeat start %0d", i), (rises.size() > i) ? rises[i] : -1, REP_B * (i + 1));
            check($sformatf("repeat busy len %0d", i), (durs.size() > i) ? durs[i] : -1, PER);
        end
        check("repeat done count", dcount, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
